fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch/issue sequencer that drives the decode stage. It holds the program counter and reads instruction words from main memory over a req/valid handshake. It presents each word with its PC to decode under a run/ok handshake, then advances sequentially or to a redirect target supplied by decode. It sits between main memory and the decode stage, on the initiator side of decode's instr/PC/run/ok interface.

Parameters:
ADDR_W, 19, width of PC and memory word address
RESET_PC, 0, PC loaded on reset
TIMEOUT, 255, maximum cycles in REQ without imem_valid before fault

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  permits starting new fetches
imem_req  out  1  memory read request, level
imem_addr  out  ADDR_W  memory word address
imem_data  in  32  read data, valid when imem_valid=1
imem_valid  in  1  read data strobe
instr  out  32  instruction to decode
PC  out  ADDR_W  address of instr
run  out  1  instr/PC valid, decode may execute
ok  in  1  decode finished current instr
redirect  in  1  with ok: take redirect_pc as next PC
redirect_pc  in  ADDR_W  branch/jump target word address
retired  out  32  count of completed instructions
fault  out  1  memory timeout, sticky

Behaviour:
- Reset (rst_n=0, async): state=IDLE, pc_r=RESET_PC, PC=RESET_PC, instr=0, run=0, imem_req=0, imem_addr=RESET_PC, retired=0, fault=0, timeout counter=0. A reset that arrives mid-operation discards the in-flight request or instruction.
- Addresses are word addresses. The next PC is pc_r+1 mod 2^ADDR_W; 0x7FFFF wraps to 0.
- All outputs are registered.
- IDLE: imem_req=0, run=0. If enable=1, go to REQ on the next edge.
- REQ: imem_req=1, imem_addr=pc_r. Both are held stable until imem_valid is sampled high. imem_valid may arrive in the first REQ cycle.
  - On valid: instr<=imem_data, PC<=pc_r, run<=1, counter cleared, go to ISSUE.
  - Each cycle without valid increments the counter. When the counter reaches TIMEOUT, imem_req<=0, fault<=1, and go to HALT.
- ISSUE: run=1. instr and PC are held stable. On ok=1:
  - pc_r<=redirect ? redirect_pc : pc_r+1.
  - retired<=retired+1, wrapping at 2^32.
  - run<=0 on the next edge.
  - Next state: REQ if enable=1, else IDLE.
  - Minimum gap between consecutive run pulses is one cycle, because run is low in REQ.
- HALT: run=0, imem_req=0, fault=1. The only exit is reset.
- ok outside ISSUE is ignored. redirect without ok is ignored.
- imem_valid outside REQ is ignored and must not change instr.
- Dropping enable in REQ or ISSUE does not abort; the current instruction completes, then the block goes to IDLE.
- ok in the same cycle that run rises cannot occur, because run is registered. ok in the first ISSUE cycle is accepted (one-cycle decode).
- A redirect to the current PC is legal and refetches the same address.

Test Plan:
1. Reset, enable=1, memory returns 0x20080005 at addr 0 after 2 cycles, decode oks after 1 cycle -> imem_addr=0, run with instr=0x20080005, PC=0, next imem_addr=1, retired=1.
2. Zero-latency memory (valid in first REQ cycle) and immediate ok, 4 instructions -> PC sequence 0,1,2,3; run high exactly 4 single cycles separated by 1-cycle gaps; retired=4.
3. ok with redirect=1, redirect_pc=0x00100 at PC=3 -> next imem_addr=0x00100 and PC=0x00100; retired increments once.
4. RESET_PC=0x7FFFF, sequential ok -> second fetch imem_addr=0x00000 (wrap).
5. TIMEOUT=8, memory never returns valid -> after 8 REQ cycles imem_req=0 and fault=1; run is never asserted; fault persists until rst_n low, then fault=0 and the block restarts at RESET_PC.
6. Deassert enable while in ISSUE, stray imem_valid with data 0xDEADBEEF while in IDLE, then pulse rst_n low while in REQ -> the instruction completes, the block goes to IDLE, instr is unchanged, and reset returns all outputs to their reset values asynchronously.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer fetching words over a req/valid memory port and issuing them to decode under run/ok.
module fetch_unit #(
  parameter int                 ADDR_W   = 19,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              imem_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] PC,
  output logic              run,
  input  logic              ok,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       retired,
  output logic              fault
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, REQ, ISSUE, HALT} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] pc_r, pc_nx;
  logic [CW-1:0] cnt;
  logic timed_out;
  always_comb begin
    state_nx = state;
    pc_nx = redirect ? redirect_pc : pc_r + 1'b1;
    timed_out = cnt == TO_LAST;
    case (state)
      IDLE:    state_nx = enable ? REQ : IDLE;
      REQ:     state_nx = imem_valid ? ISSUE : (timed_out ? HALT : REQ);
      ISSUE:   state_nx = ok ? (enable ? REQ : IDLE) : ISSUE;
      default: state_nx = HALT;
    endcase
  end
  // Outputs are registered alongside the state so each transition sets them for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc_r      <= RESET_PC;
      PC        <= RESET_PC;
      instr     <= '0;
      run       <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      retired   <= '0;
      fault     <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (enable) begin
          imem_req  <= 1'b1;
          imem_addr <= pc_r;
        end
        REQ: if (imem_valid) begin
          imem_req <= 1'b0;
          instr    <= imem_data;
          PC       <= pc_r;
          run      <= 1'b1;
          cnt      <= '0;
        end else if (timed_out) begin
          imem_req <= 1'b0;
          fault    <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        ISSUE: if (ok) begin
          pc_r      <= pc_nx;
          retired   <= retired + 32'd1;
          run       <= 1'b0;
          imem_req  <= enable;
          imem_addr <= pc_nx;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus randomized fetch/issue sequences checked against a PC/retire model.
module tb_fetch_unit;
  localparam int AW = 19;
  localparam logic [AW-1:0] RPC = 19'h7FFFF;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic imem_valid = 1'b0;
  logic [31:0] instr;
  logic [AW-1:0] PC;
  logic run;
  logic ok = 1'b0;
  logic redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [31:0] retired;
  logic fault;
  int compared = 0;
  int mismatched = 0;
  logic [AW-1:0] exp_pc;
  logic [31:0] exp_ret;
  logic [31:0] last_instr;

  fetch_unit #(.ADDR_W(AW), .RESET_PC(RPC), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_valid(imem_valid), .instr(instr), .PC(PC), .run(run),
    .ok(ok), .redirect(redirect), .redirect_pc(redirect_pc), .retired(retired), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed hang expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_run"}, run, 0);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_addr"}, imem_addr, RPC);
    chk({tag, "_pc"}, PC, RPC);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_retired"}, retired, 0);
    chk({tag, "_fault"}, fault, 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1 chk_reset(tag);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = RPC;
    exp_ret = 0;
    last_instr = 0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", imem_req, 1);
  endtask

  // One complete instruction: memory answers after lat cycles, decode oks after okd cycles.
  task automatic fetch(input int lat, input int okd, input bit redir, input logic [AW-1:0] tgt, input bit en_after);
    logic [31:0] d;
    d = $urandom;
    wait_req();
    chk("req_addr", imem_addr, exp_pc);
    repeat (lat) begin
      @(negedge clk);
      chk("req_hold", {imem_req, imem_addr}, {1'b1, exp_pc});
      chk("run_low_req", run, 0);
    end
    imem_valid = 1'b1;
    imem_data = d;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_data = $urandom;
    chk("run_rise", run, 1);
    chk("instr", instr, d);
    chk("pc", PC, exp_pc);
    chk("req_drop", imem_req, 0);
    last_instr = d;
    repeat (okd) begin
      imem_valid = 1'($urandom);
      imem_data = $urandom;
      redirect = 1'($urandom);
      redirect_pc = AW'($urandom);
      @(negedge clk);
      chk("issue_hold", {run, PC, instr}, {1'b1, exp_pc, d});
    end
    imem_valid = 1'b0;
    enable = en_after;
    ok = 1'b1;
    redirect = redir;
    redirect_pc = tgt;
    @(negedge clk);
    ok = 1'b0;
    redirect = 1'b0;
    exp_pc = redir ? tgt : exp_pc + 1'b1;
    exp_ret++;
    chk("run_fall", run, 0);
    chk("retired", retired, exp_ret);
    chk("next_req", imem_req, en_after);
    if (en_after) chk("next_addr", imem_addr, exp_pc);
  endtask

  initial begin
    int n;
    #2;
    do_reset("rst0");
    enable = 1'b1;
    fetch(2, 1, 0, '0, 1);
    chk("wrap_addr", imem_addr, 0);
    repeat (4) fetch(0, 0, 0, '0, 1);
    chk("seq_retired", retired, 5);
    fetch(0, 0, 1, 19'h00100, 1);
    chk("redir_addr", imem_addr, 19'h00100);
    fetch(1, 0, 0, '0, 1);
    chk("redir_pc", PC, 19'h00100);
    fetch(1, 0, 1, exp_pc, 1);
    chk("self_redir", imem_addr, 19'h00101);
    for (int i = 0; i < 40; i++)
      fetch(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
            AW'($urandom), 1);
    fetch(1, 1, 0, '0, 0);
    repeat (3) begin
      imem_valid = 1'b1;
      imem_data = 32'hDEADBEEF;
      @(negedge clk);
      chk("idle_quiet", {imem_req, run}, 0);
      chk("idle_instr", instr, last_instr);
    end
    imem_valid = 1'b0;
    enable = 1'b1;
    wait_req();
    chk("resume_addr", imem_addr, exp_pc);
    #2 do_reset("rst_req");
    wait_req();
    chk("restart_addr", imem_addr, RPC);
    n = 0;
    while (imem_req && n < 50) begin
      chk("to_run_low", run, 0);
      n++;
      @(negedge clk);
    end
    chk("to_cycles", n, 8);
    chk("to_fault", fault, 1);
    repeat (5) begin
      @(negedge clk);
      chk("halt_hold", {fault, imem_req, run}, 3'b100);
    end
    do_reset("rst_halt");
    fetch(0, 0, 0, '0, 1);
    chk("post_halt_pc", PC, RPC);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
